fetch_unit: RTL

Instruction fetch stage that produces the instruction stream consumed by the main control decoder. It owns the PC, issues single-outstanding requests to instruction memory, holds each returned word in an instruction register, and presents it with a valid/ready handshake. The Op field goes to the decoder. Taken branches from execute redirect the PC and discard in-flight or held instructions.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam int OP_W    = 4;
  localparam int PC_STEP = 4;
  // Widest address the helper accepts; callers cast to and from their width.
  localparam int ALIGN_W = 64;

  function automatic logic [ALIGN_W-1:0] align_pc(input logic [ALIGN_W-1:0] addr);
    return {addr[ALIGN_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, aligned redirect target, +4 step or hold.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = ADDR_W'(align_pc(ALIGN_W'(redirect_pc)));
    end else if (inc_en) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, instruction
// register with valid/ready handshake, and branch redirect with flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0]  pc;
  logic               pc_inc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inc_en         (pc_inc),
    .pc             (pc)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    drop_addr_d = drop_addr_q;
    pc_inc      = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          // The request is still in flight: park its address until it returns.
          if (!imem_rvalid) begin
            state_d     = S_DROP;
            drop_addr_d = pc;
          end
        end else if (imem_rvalid) begin
          state_d    = S_HOLD;
          instr_d    = imem_rdata;
          instr_pc_d = pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (instr_ready) begin
          state_d = S_REQ;
          pc_inc  = 1'b1;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign imem_req    = !rst && (state_q != S_HOLD);
  assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign op          = instr_q[INSTR_W-1 -: OP_W];
  assign pc_out      = instr_pc_q;

endmodule
